// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM encoding, sizes,
// and the active-low seven-segment table ({g,f,e,d,c,b,a}).
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NDIGITS   = 6;
  localparam int unsigned NBITS     = 20;
  localparam int unsigned BCD_W     = 4 * NDIGITS;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned SCORE_W   = 32;
  localparam int unsigned MAX_SCORE = 999999;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Saturate anything above six decimal digits to 999999.
  function automatic logic [NBITS-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_W'(MAX_SCORE)) ? NBITS'(MAX_SCORE) : s[NBITS-1:0];
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score input and display outputs of the score display block.
interface score_display_if;
  import score_display_pkg::*;

  logic [SCORE_W-1:0] score;
  logic [SEG_W-1:0]   hex0;
  logic [SEG_W-1:0]   hex1;
  logic [SEG_W-1:0]   hex2;
  logic [SEG_W-1:0]   hex3;
  logic [SEG_W-1:0]   hex4;
  logic [SEG_W-1:0]   hex5;
  logic               busy;
  logic               update;

  modport master (output score, input hex0, hex1, hex2, hex3, hex4, hex5, busy, update);
  modport slave  (input score, output hex0, hex1, hex2, hex3, hex4, hex5, busy, update);

endinterface

// File: rtl/score_display_seg7_decoder.sv
// One BCD digit to an active-low segment pattern; blank forces all segments off.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) seg_c = SEG_TABLE[digit];
  end

endmodule

// File: rtl/score_display.sv
// Converts a binary score to six blanked seven-segment digits with a
// double-dabble FSM; the display only changes on the single update cycle.
module score_display
  import score_display_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  score_display_if.slave  bus
);

  localparam logic [NDIGITS-1:0][SEG_W-1:0] HEX_RST =
    {{(NDIGITS-1){SEG_BLANK}}, SEG_TABLE[0]};

  state_t                        state, state_n;
  logic [SCORE_W-1:0]            last_score, last_score_n;
  logic [NBITS-1:0]              bin, bin_n;
  logic [BCD_W-1:0]              bcd, bcd_n, bcd_adj;
  logic [CNT_W-1:0]              cnt, cnt_n;
  logic [NDIGITS-1:0][SEG_W-1:0] hex, hex_n;
  logic [NDIGITS-1:0][SEG_W-1:0] seg;
  logic [NDIGITS-1:0]            blank;
  logic                          busy, busy_n;
  logic                          update, update_n;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit is blank when it and every digit above it are zero; hex0 never blanks.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int i = int'(NDIGITS) - 1; i >= 1; i--) begin
      run      = run && (bcd[4*i +: 4] == 4'd0);
      blank[i] = run;
    end
  end

  for (genvar g = 0; g < int'(NDIGITS); g++) begin : g_dec
    seg7_decoder u_dec (
      .digit (bcd[4*g +: 4]),
      .blank (blank[g]),
      .seg_c (seg[g])
    );
  end

  always_comb begin
    state_n      = state;
    last_score_n = last_score;
    bin_n        = bin;
    bcd_n        = bcd;
    cnt_n        = cnt;
    hex_n        = hex;
    update_n     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.score != last_score) begin
          last_score_n = bus.score;
          bin_n        = clamp_score(bus.score);
          bcd_n        = '0;
          cnt_n        = '0;
          state_n      = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_n, bin_n} = {bcd_adj, bin} << 1;
        cnt_n          = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NBITS - 1)) state_n = DONE;
      end
      DONE: begin
        hex_n    = seg;
        update_n = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_score <= '0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      hex        <= HEX_RST;
      busy       <= 1'b0;
      update     <= 1'b0;
    end else begin
      state      <= state_n;
      last_score <= last_score_n;
      bin        <= bin_n;
      bcd        <= bcd_n;
      cnt        <= cnt_n;
      hex        <= hex_n;
      busy       <= busy_n;
      update     <= update_n;
    end
  end

  assign bus.hex0   = hex[0];
  assign bus.hex1   = hex[1];
  assign bus.hex2   = hex[2];
  assign bus.hex3   = hex[3];
  assign bus.hex4   = hex[4];
  assign bus.hex5   = hex[5];
  assign bus.busy   = busy;
  assign bus.update = update;

endmodule
